// File: rtl/nios_timer_pkg.sv
// nios_timer_pkg: register offsets and bit positions shared by the timer array
package nios_timer_pkg;
    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_e;
    localparam int CTRL_ITO = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP = 3;
    localparam int CTRL_PRE_LSB = 8;
    localparam int CTRL_PRE_MSB = 15;
    localparam int STAT_TO = 0;
    localparam int STAT_RUN = 1;
endpackage

// File: rtl/nios_timer_channel.sv
// nios_timer_channel: one prescaled down-counter with snapshot, TO/RUN and interrupt
module nios_timer_channel
    import nios_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       wr,
    input  logic [31:0]      wdata,
    output logic [3:0][31:0] regs,
    output logic             irq
);
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d;
    logic [7:0] pcnt_q, pcnt_d, presc_q, presc_d;
    logic ito_q, ito_d, cont_q, cont_d, run_q, run_d, to_q, to_d;
    logic tick, timeout, wr_c, wr_p, unused_wd;
    assign unused_wd = ^wdata;
    always_comb begin
        wr_c = wr[REG_CONTROL];
        wr_p = wr[REG_PERIOD];
        tick = run_q && pcnt_q == '0;
        timeout = tick && cnt_q == '0;
        pcnt_d = wr_p ? '0 : !run_q ? pcnt_q : pcnt_q == '0 ? presc_q : pcnt_q - 8'd1;
        cnt_d = wr_p ? wdata[CNT_W-1:0] : !tick ? cnt_q : timeout ? per_q : cnt_q - CNT_W'(1);
        per_d = wr_p ? wdata[CNT_W-1:0] : per_q;
        // a timeout on the same edge as a STATUS write must not be lost
        to_d = timeout || (to_q && !wr[REG_STATUS]);
        run_d = wr_c && wdata[CTRL_START] ? 1'b1 :
                wr_c && wdata[CTRL_STOP] ? 1'b0 :
                wr_p ? 1'b0 :
                timeout && !cont_q ? 1'b0 : run_q;
        ito_d = wr_c ? wdata[CTRL_ITO] : ito_q;
        cont_d = wr_c ? wdata[CTRL_CONT] : cont_q;
        presc_d = wr_c ? wdata[CTRL_PRE_MSB:CTRL_PRE_LSB] : presc_q;
        snap_d = wr[REG_SNAP] ? cnt_q : snap_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= CNT_W'(RESET_PERIOD);
            per_q <= CNT_W'(RESET_PERIOD);
            snap_q <= '0;
            pcnt_q <= '0;
            presc_q <= '0;
            ito_q <= 1'b0;
            cont_q <= 1'b0;
            run_q <= 1'b0;
            to_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            snap_q <= snap_d;
            pcnt_q <= pcnt_d;
            presc_q <= presc_d;
            ito_q <= ito_d;
            cont_q <= cont_d;
            run_q <= run_d;
            to_q <= to_d;
        end
    end
    assign regs[REG_STATUS] = 32'({run_q, to_q});
    assign regs[REG_CONTROL] = 32'({presc_q, 6'b0, cont_q, ito_q});
    assign regs[REG_PERIOD] = 32'(per_q);
    assign regs[REG_SNAP] = 32'(snap_q);
    assign irq = to_q && ito_q;
endmodule

// File: rtl/nios_system_timer_array.sv
// nios_system_timer_array: Avalon-MM array of NUM_CH interval timers with ORed irq
module nios_system_timer_array
    import nios_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+1:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [NUM_CH-1:0]          irq_vec,
    output logic                       irq
);
    logic [3:0] ch;
    logic [1:0] sel;
    logic wr_en;
    logic [3:0][31:0] regs [NUM_CH];
    logic [31:0] readdata_q, readdata_d;
    assign ch = 4'(address >> 2);
    assign sel = address[1:0];
    assign wr_en = chipselect && !write_n;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nios_timer_channel #(.CNT_W(CNT_W), .RESET_PERIOD(RESET_PERIOD)) u_ch (
            .clk(clk),
            .reset_n(reset_n),
            .wr((wr_en && ch == 4'(i)) ? 4'b0001 << sel : 4'b0000),
            .wdata(writedata),
            .regs(regs[i]),
            .irq(irq_vec[i])
        );
    end
    always_comb begin
        readdata_d = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch == 4'(k)) readdata_d = regs[k][sel];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) readdata_q <= '0;
        else readdata_q <= readdata_d;
    end
    assign readdata = readdata_q;
    assign irq = |irq_vec;
endmodule
